// File: rtl/axi_copy_ctrl.sv
// ---------------------------------------------------------------------------
// AxiCopyCtrl -- address sequencer for a memory-to-memory copy engine.
//
// A job copies len transfers from a source region to a destination region.
// The block issues read addresses, waits for each read beat to be reported
// back before issuing the matching write address, and counts write responses
// until every transfer has been acknowledged. The number of reads whose write
// response is still pending is capped at MAX_OUTSTANDING.
//
// Ports:
//   clk, rst                       clock and synchronous active-high reset
//   i_start, i_src_addr,
//   i_dst_addr, i_len              job request, sampled when a start is taken
//   o_busy, o_done, o_err          job status (o_err sticky per job)
//   o_rd_addr_vld/o_rd_addr/
//   i_rd_addr_rdy                  read-address handshake
//   i_rd_data_vld                  one pulse per read beat delivered
//   o_wr_addr_vld/o_wr_addr/
//   i_wr_addr_rdy                  write-address handshake
//   i_wr_resp_vld, i_wr_resp_err   one pulse per write response, error flag
// ---------------------------------------------------------------------------
module axi_copy_ctrl #(
    parameter int ADDR_WIDTH      = 32,
    parameter int LEN_WIDTH       = 16,
    parameter int BEAT_SHIFT      = 2,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_src_addr,
    input  logic [ADDR_WIDTH-1:0] i_dst_addr,
    input  logic [LEN_WIDTH-1:0]  i_len,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic                  o_rd_addr_vld,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    input  logic                  i_rd_addr_rdy,
    input  logic                  i_rd_data_vld,
    output logic                  o_wr_addr_vld,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    input  logic                  i_wr_addr_rdy,
    input  logic                  i_wr_resp_vld,
    input  logic                  i_wr_resp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [LEN_WIDTH-1:0] MAX_OS = LEN_WIDTH'(MAX_OUTSTANDING);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
    logic [LEN_WIDTH-1:0]  rdata_cnt_q, rdata_cnt_d;
    logic [LEN_WIDTH-1:0]  wr_cnt_q, wr_cnt_d;
    logic [LEN_WIDTH-1:0]  resp_cnt_q, resp_cnt_d;
    logic                  err_q, err_d;

    logic                  running;
    logic [LEN_WIDTH-1:0]  in_flight;
    logic                  rd_fire;
    logic                  wr_fire;
    logic                  data_take;
    logic                  resp_take;

    // Handshake outputs depend only on registered state, so once a valid is
    // raised it and its address stay put until the matching fire moves the
    // counter. in_flight counts reads issued but not yet acknowledged by a
    // write response; it never goes negative because responses follow writes,
    // which follow reads.
    assign running       = (state_q == RUN);
    assign in_flight     = rd_cnt_q - resp_cnt_q;
    assign o_rd_addr_vld = running && (rd_cnt_q < len_q) && (in_flight < MAX_OS);
    assign o_wr_addr_vld = running && (wr_cnt_q < len_q) && (wr_cnt_q < rdata_cnt_q);
    assign o_rd_addr     = src_q + (ADDR_WIDTH'(rd_cnt_q) << BEAT_SHIFT);
    assign o_wr_addr     = dst_q + (ADDR_WIDTH'(wr_cnt_q) << BEAT_SHIFT);
    assign o_busy        = running;
    assign o_done        = (state_q == DONE);
    assign o_err         = err_q;

    // Beat and response pulses only count while a job runs and only up to
    // len, so stragglers from an abandoned job or extra pulses are dropped.
    assign rd_fire   = o_rd_addr_vld && i_rd_addr_rdy;
    assign wr_fire   = o_wr_addr_vld && i_wr_addr_rdy;
    assign data_take = running && i_rd_data_vld && (rdata_cnt_q < len_q);
    assign resp_take = running && i_wr_resp_vld && (resp_cnt_q < len_q);

    // Next-state logic. A start is only honoured from IDLE or DONE; it latches
    // the job and clears all bookkeeping. In RUN the four counters advance
    // independently, and the job finishes on the edge that counts the last
    // write response. An error response marks the job but does not stop it.
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        len_d       = len_q;
        rd_cnt_d    = rd_cnt_q;
        rdata_cnt_d = rdata_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        resp_cnt_d  = resp_cnt_q;
        err_d       = err_q;

        case (state_q)
            IDLE, DONE: begin
                if (i_start) begin
                    src_d       = i_src_addr;
                    dst_d       = i_dst_addr;
                    len_d       = i_len;
                    rd_cnt_d    = '0;
                    rdata_cnt_d = '0;
                    wr_cnt_d    = '0;
                    resp_cnt_d  = '0;
                    err_d       = 1'b0;
                    state_d     = (i_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (rd_fire)   rd_cnt_d    = rd_cnt_q + 1'b1;
                if (data_take) rdata_cnt_d = rdata_cnt_q + 1'b1;
                if (wr_fire)   wr_cnt_d    = wr_cnt_q + 1'b1;
                if (resp_take) begin
                    resp_cnt_d = resp_cnt_q + 1'b1;
                    if (i_wr_resp_err) err_d = 1'b1;
                    if (resp_cnt_q == len_q - 1'b1) state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register. Reset abandons any job outright: returning to IDLE
    // drops both valids in the very next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            rd_cnt_q    <= '0;
            rdata_cnt_q <= '0;
            wr_cnt_q    <= '0;
            resp_cnt_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            len_q       <= len_d;
            rd_cnt_q    <= rd_cnt_d;
            rdata_cnt_q <= rdata_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            resp_cnt_q  <= resp_cnt_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_axi_copy_ctrl.sv
// ---------------------------------------------------------------------------
// tb_axi_copy_ctrl -- self-checking bench for axi_copy_ctrl.
//
// The DUT runs with MAX_OUTSTANDING=2 so throttling is easy to provoke. A
// small responder inside applyStimulus returns one read beat the cycle after
// each read-address fire and one write response the cycle after each
// write-address fire, each independently switchable. Complete jobs come from
// a table of hand-computed vectors; throttling, data gating, start-in-RUN and
// reset mid-job are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_axi_copy_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [31:0] i_src_addr;
    logic [31:0] i_dst_addr;
    logic [15:0] i_len;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic        o_rd_addr_vld;
    logic [31:0] o_rd_addr;
    logic        i_rd_addr_rdy;
    logic        i_rd_data_vld;
    logic        o_wr_addr_vld;
    logic [31:0] o_wr_addr;
    logic        i_wr_addr_rdy;
    logic        i_wr_resp_vld;
    logic        i_wr_resp_err;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] rdLog[$];
    logic [31:0] wrLog[$];
    int          dataOwed;
    int          respOwed;
    int          respIdx;
    int          errIdx;
    bit          autoData;
    bit          autoResp;
    bit          sawWrVld;

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] len;
        int          errAt;
        logic [31:0] expRdLast;
        logic [31:0] expWrLast;
        logic        expErr;
    } jobVec_t;

    jobVec_t jobs[4];

    axi_copy_ctrl #(
        .ADDR_WIDTH      (32),
        .LEN_WIDTH       (16),
        .BEAT_SHIFT      (2),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (i_start),
        .i_src_addr    (i_src_addr),
        .i_dst_addr    (i_dst_addr),
        .i_len         (i_len),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_err         (o_err),
        .o_rd_addr_vld (o_rd_addr_vld),
        .o_rd_addr     (o_rd_addr),
        .i_rd_addr_rdy (i_rd_addr_rdy),
        .i_rd_data_vld (i_rd_data_vld),
        .o_wr_addr_vld (o_wr_addr_vld),
        .o_wr_addr     (o_wr_addr),
        .i_wr_addr_rdy (i_wr_addr_rdy),
        .i_wr_resp_vld (i_wr_resp_vld),
        .i_wr_resp_err (i_wr_resp_err)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Compare one observed value with its expected value and keep the tally.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Advance one clock. Called #1 after a rising edge: log the fires that
    // the coming edge will perform, drive the responder pulses for this
    // cycle, then wait until #1 after the next edge.
    task automatic applyStimulus();
        bit rdFire;
        bit wrFire;
        rdFire = o_rd_addr_vld && i_rd_addr_rdy;
        wrFire = o_wr_addr_vld && i_wr_addr_rdy;
        if (rdFire) rdLog.push_back(o_rd_addr);
        if (wrFire) wrLog.push_back(o_wr_addr);
        if (o_wr_addr_vld) sawWrVld = 1'b1;
        if (autoData && dataOwed > 0) begin
            i_rd_data_vld = 1'b1;
            dataOwed--;
        end else begin
            i_rd_data_vld = 1'b0;
        end
        if (autoResp && respOwed > 0) begin
            i_wr_resp_vld = 1'b1;
            i_wr_resp_err = (respIdx == errIdx);
            respIdx++;
            respOwed--;
        end else begin
            i_wr_resp_vld = 1'b0;
            i_wr_resp_err = 1'b0;
        end
        if (rdFire) dataOwed++;
        if (wrFire) respOwed++;
        @(posedge clk);
        #1;
    endtask

    // Clear the responder and logs before a new job.
    task automatic clearResponder();
        rdLog.delete();
        wrLog.delete();
        dataOwed = 0;
        respOwed = 0;
        respIdx  = 0;
        sawWrVld = 1'b0;
    endtask

    // Pulse start for one edge with the given job parameters.
    task automatic pulseStart(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] len);
        i_src_addr = src;
        i_dst_addr = dst;
        i_len      = len;
        i_start    = 1'b1;
        applyStimulus();
        i_start    = 1'b0;
    endtask

    // Wait for o_done with a cycle budget; an expired budget is a failure.
    task automatic waitDone(input string name);
        int cycles;
        cycles = 0;
        while (!o_done && cycles < 300) begin
            applyStimulus();
            cycles++;
        end
        checkOutput({name, "_done"}, {31'd0, o_done}, 32'd1);
    endtask

    // Run a whole job with the responder fully enabled and check status,
    // fire counts and every address against the expected sequence.
    task automatic runJob(input string name, input jobVec_t v);
        logic [31:0] expAddr;
        clearResponder();
        autoData = 1'b1;
        autoResp = 1'b1;
        errIdx   = v.errAt;
        pulseStart(v.src, v.dst, v.len);
        checkOutput({name, "_busy_after_start"}, {31'd0, o_busy}, 32'd1);
        checkOutput({name, "_done_cleared"},     {31'd0, o_done}, 32'd0);
        checkOutput({name, "_err_cleared"},      {31'd0, o_err},  32'd0);
        waitDone(name);
        checkOutput({name, "_busy_end"}, {31'd0, o_busy}, 32'd0);
        checkOutput({name, "_err"},      {31'd0, o_err},  {31'd0, v.expErr});
        checkOutput({name, "_rd_count"}, rdLog.size(),    {16'd0, v.len});
        checkOutput({name, "_wr_count"}, wrLog.size(),    {16'd0, v.len});
        for (int i = 0; i < int'(v.len); i++) begin
            expAddr = v.src + 32'(i * 4);
            if (i < rdLog.size()) checkOutput({name, "_rd_addr"}, rdLog[i], expAddr);
            expAddr = v.dst + 32'(i * 4);
            if (i < wrLog.size()) checkOutput({name, "_wr_addr"}, wrLog[i], expAddr);
        end
        if (rdLog.size() > 0) checkOutput({name, "_rd_last"}, rdLog[rdLog.size()-1], v.expRdLast);
        if (wrLog.size() > 0) checkOutput({name, "_wr_last"}, wrLog[wrLog.size()-1], v.expWrLast);
    endtask

    // Check that every output is at its reset value.
    task automatic checkAllZero(input string name);
        checkOutput({name, "_busy"},     {31'd0, o_busy},        32'd0);
        checkOutput({name, "_done"},     {31'd0, o_done},        32'd0);
        checkOutput({name, "_err"},      {31'd0, o_err},         32'd0);
        checkOutput({name, "_rd_vld"},   {31'd0, o_rd_addr_vld}, 32'd0);
        checkOutput({name, "_wr_vld"},   {31'd0, o_wr_addr_vld}, 32'd0);
        checkOutput({name, "_rd_addr"},  o_rd_addr,              32'd0);
        checkOutput({name, "_wr_addr"},  o_wr_addr,              32'd0);
    endtask

    // Main sequence: reset, table-driven jobs, then the multi-cycle corners.
    initial begin
        jobs[0] = '{src: 32'h0000_0000, dst: 32'h0000_1000, len: 16'd4, errAt: -1,
                    expRdLast: 32'h0000_000C, expWrLast: 32'h0000_100C, expErr: 1'b0};
        jobs[1] = '{src: 32'hFFFF_FFFC, dst: 32'h0000_2000, len: 16'd2, errAt: -1,
                    expRdLast: 32'h0000_0000, expWrLast: 32'h0000_2004, expErr: 1'b0};
        jobs[2] = '{src: 32'h0000_0100, dst: 32'h0000_0200, len: 16'd3, errAt: 1,
                    expRdLast: 32'h0000_0108, expWrLast: 32'h0000_0208, expErr: 1'b1};
        jobs[3] = '{src: 32'h0000_0040, dst: 32'h0000_0080, len: 16'd1, errAt: -1,
                    expRdLast: 32'h0000_0040, expWrLast: 32'h0000_0080, expErr: 1'b0};

        rst           = 1'b1;
        i_start       = 1'b0;
        i_src_addr    = '0;
        i_dst_addr    = '0;
        i_len         = '0;
        i_rd_addr_rdy = 1'b1;
        i_wr_addr_rdy = 1'b1;
        i_rd_data_vld = 1'b0;
        i_wr_resp_vld = 1'b0;
        i_wr_resp_err = 1'b0;
        autoData      = 1'b0;
        autoResp      = 1'b0;
        errIdx        = -1;
        clearResponder();

        @(posedge clk);
        @(posedge clk);
        #1;
        checkAllZero("reset");
        rst = 1'b0;
        applyStimulus();

        // Table-driven complete jobs; job 3 follows the error job and so
        // also shows a new start clearing o_err and o_done.
        for (int j = 0; j < 4; j++) begin
            $display("[TB] job %0d: src=0x%08h dst=0x%08h len=%0d", j, jobs[j].src, jobs[j].dst, jobs[j].len);
            runJob($sformatf("job%0d", j), jobs[j]);
            applyStimulus();
        end

        // Zero-length job: done one cycle after start, no address fires.
        clearResponder();
        pulseStart(32'h0000_0500, 32'h0000_0600, 16'd0);
        checkOutput("len0_done", {31'd0, o_done}, 32'd1);
        checkOutput("len0_busy", {31'd0, o_busy}, 32'd0);
        applyStimulus();
        applyStimulus();
        checkOutput("len0_rd_fires", rdLog.size(), 32'd0);
        checkOutput("len0_wr_fires", wrLog.size(), 32'd0);

        // Throttle: responses withheld, so only two reads may issue. A start
        // pulsed during RUN must not disturb the job.
        clearResponder();
        autoData = 1'b1;
        autoResp = 1'b0;
        errIdx   = -1;
        pulseStart(32'h0000_3000, 32'h0000_4000, 16'd6);
        for (int c = 0; c < 12; c++) applyStimulus();
        checkOutput("throttle_rd_fires", rdLog.size(), 32'd2);
        checkOutput("throttle_rd_vld",   {31'd0, o_rd_addr_vld}, 32'd0);
        pulseStart(32'h0000_9000, 32'h0000_A000, 16'd1);
        checkOutput("run_start_busy",     {31'd0, o_busy}, 32'd1);
        checkOutput("run_start_rd_vld",   {31'd0, o_rd_addr_vld}, 32'd0);
        checkOutput("run_start_rd_fires", rdLog.size(), 32'd2);
        autoResp = 1'b1;
        waitDone("throttle");
        checkOutput("throttle_total_rd", rdLog.size(), 32'd6);
        checkOutput("throttle_total_wr", wrLog.size(), 32'd6);
        if (rdLog.size() == 6) checkOutput("throttle_rd_last", rdLog[5], 32'h0000_3014);
        if (wrLog.size() == 6) checkOutput("throttle_wr_last", wrLog[5], 32'h0000_4014);
        checkOutput("throttle_err", {31'd0, o_err}, 32'd0);

        // Data gating: no read beats come back, so writes never go valid
        // while reads run up to the outstanding limit.
        clearResponder();
        autoData = 1'b0;
        autoResp = 1'b1;
        pulseStart(32'h0000_5000, 32'h0000_5800, 16'd5);
        for (int c = 0; c < 10; c++) applyStimulus();
        checkOutput("gate_rd_fires", rdLog.size(), 32'd2);
        checkOutput("gate_wr_seen",  {31'd0, sawWrVld}, 32'd0);
        checkOutput("gate_wr_fires", wrLog.size(), 32'd0);

        // Reset mid-job after two of five reads: everything drops at once.
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        checkAllZero("midreset");
        dataOwed = 0;

        // A stray error response after reset must be ignored.
        autoResp = 1'b1;
        respOwed = 1;
        errIdx   = respIdx;
        applyStimulus();
        applyStimulus();
        checkOutput("late_resp_err",   {31'd0, o_err},         32'd0);
        checkOutput("late_resp_done",  {31'd0, o_done},        32'd0);
        checkOutput("late_resp_rdvld", {31'd0, o_rd_addr_vld}, 32'd0);
        checkOutput("late_resp_fires", rdLog.size(),           32'd2);

        runJob("post_reset", '{src: 32'h0000_6000, dst: 32'h0000_7000, len: 16'd1, errAt: -1,
                               expRdLast: 32'h0000_6000, expWrLast: 32'h0000_7000, expErr: 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/axi_copy_ctrl.md
AXI_COPY_CTRL -- requirements
Module: axi_copy_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32: address width of both channels.
REQ-002 The block SHALL have parameter LEN_WIDTH, default 16: width of the transfer-count field and all internal counters.
REQ-003 The block SHALL have parameter BEAT_SHIFT, default 2: the address increment per transfer is 2^BEAT_SHIFT bytes.
REQ-004 The block SHALL have parameter MAX_OUTSTANDING, default 8, legal range 1..2^LEN_WIDTH-1: maximum number of accepted read addresses whose write response has not yet returned.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset, with ports as follows:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- i_start  in  1  start pulse
- i_src_addr  in  ADDR_WIDTH  read base address, sampled on accepted start
- i_dst_addr  in  ADDR_WIDTH  write base address, sampled on accepted start
- i_len  in  LEN_WIDTH  number of transfers, sampled on accepted start
- o_busy  out  1  job in progress
- o_done  out  1  job complete; level signal
- o_err  out  1  sticky: at least one error write response in the current job
- o_rd_addr_vld / o_rd_addr / i_rd_addr_rdy  out/out/in  1/ADDR_WIDTH/1  read-address handshake
- i_rd_data_vld  in  1  one read beat accepted downstream; one pulse per beat
- o_wr_addr_vld / o_wr_addr / i_wr_addr_rdy  out/out/in  1/ADDR_WIDTH/1  write-address handshake
- i_wr_resp_vld  in  1  write response; one pulse per transfer
- i_wr_resp_err  in  1  the response is an error; qualified by i_wr_resp_vld

Function
REQ-006 Fire conditions SHALL be: rd_fire = o_rd_addr_vld & i_rd_addr_rdy; wr_fire = o_wr_addr_vld & i_wr_addr_rdy.
REQ-007 The FSM SHALL have states IDLE, RUN and DONE.
- IDLE/DONE -> RUN on i_start when i_len != 0.
- IDLE/DONE -> DONE on i_start when i_len == 0; o_done is high the next cycle.
- RUN -> DONE on the cycle the final (i_len-th) write response is counted.
REQ-008 i_start while in RUN SHALL be ignored: no parameter resample and no counter change.
REQ-009 An accepted start SHALL latch src, dst and len, clear all four counters (rd_cnt, rdata_cnt, wr_cnt, resp_cnt) and clear o_err and o_done.
REQ-010 o_busy SHALL equal (state == RUN); o_done SHALL equal (state == DONE).
REQ-011 Address outputs SHALL be computed modulo 2^ADDR_WIDTH, with no wrap detection:
- o_rd_addr = src + (rd_cnt << BEAT_SHIFT)
- o_wr_addr = dst + (wr_cnt << BEAT_SHIFT)
REQ-012 o_rd_addr_vld SHALL be asserted in RUN when rd_cnt < len and (rd_cnt - resp_cnt) < MAX_OUTSTANDING.
REQ-013 o_wr_addr_vld SHALL be asserted in RUN when wr_cnt < len and wr_cnt < rdata_cnt, so that a write is issued only for a beat already read.
REQ-014 Valid-signal and address generation SHALL be combinational from registered state. Once o_*_vld is asserted, it and its address SHALL hold until the fire, because the counters only change on fire.
REQ-015 Counter increments SHALL be:
- rd_cnt on rd_fire
- rdata_cnt on i_rd_data_vld
- wr_cnt on wr_fire
- resp_cnt on i_wr_resp_vld
REQ-016 The four counter increments SHALL be independent of each other; any combination of them may occur in the same cycle.
REQ-017 i_rd_data_vld and i_wr_resp_vld arriving outside RUN, or beyond len, SHALL be ignored and SHALL NOT change any counter.
REQ-018 o_err SHALL be set on i_wr_resp_vld & i_wr_resp_err in RUN and stay set through DONE until the next accepted start; an error SHALL NOT abort the job.
REQ-019 Throughput: with all ready signals high and data/responses returned in one cycle, the block SHALL sustain one read-address fire per cycle.
REQ-020 i_len = 2^LEN_WIDTH-1 SHALL complete without counter overflow; counters are LEN_WIDTH bits wide and comparisons are unsigned.

Reset
REQ-021 While rst is high at a clock edge, the block SHALL enter IDLE with all counters, latched parameters and outputs at 0: o_busy=0, o_done=0, o_err=0, o_rd_addr_vld=0, o_wr_addr_vld=0.
REQ-022 rst asserted mid-job SHALL abandon the job immediately with no further address issued. Responses arriving after reset SHALL be ignored per REQ-017.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Basic copy: src=0x0, dst=0x1000, len=4, all ready high, 1-cycle data/response return -> read addresses 0x0,0x4,0x8,0xC; write addresses 0x1000..0x100C in order; o_done=1 after the 4th response; o_err=0.
- Throttle: MAX_OUTSTANDING=2, len=6, write responses withheld -> exactly 2 read fires, then o_rd_addr_vld=0 until a response arrives.
- Data gating: i_rd_data_vld never pulsed -> o_wr_addr_vld stays 0 while reads proceed up to the outstanding limit.
- Error and restart: the 2nd response of len=3 has err=1 -> o_err=1, job completes with o_done=1; a new start clears o_err and o_done the next cycle.
- Edge cases: len=0 -> o_done=1 one cycle after start with no address fires; a start during RUN changes nothing; src=0xFFFFFFFC, len=2 -> second read address is 0x0.
- Reset mid-job: rst for one cycle after 2 of 5 read fires -> all outputs 0 next cycle; a later start with len=1 completes normally.
